sine_dds: RTL and testbench

SINE_DDS -- requirements
Module: sine_dds

---
 rtl/sine_dds_pkg.sv | 43 ++++
 rtl/sine_quarter_rom.sv | 35 +++
 rtl/sine_dds.sv | 113 +++++++++++
 tb/tb_sine_dds.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sine_dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sine_dds_pkg
// Description : Shared constants and ROM-content function for the sine DDS.
// Revision    : 1.0 - initial release
// ============================================================================
package sine_dds_pkg;

    localparam int c_phase_w_default = 24;
    localparam int c_addr_w_default  = 8;
    localparam int c_out_w_default   = 9;

    localparam logic [1:0] c_quad_q0 = 2'd0;
    localparam logic [1:0] c_quad_q1 = 2'd1;
    localparam logic [1:0] c_quad_q2 = 2'd2;
    localparam logic [1:0] c_quad_q3 = 2'd3;

    localparam int c_unity_gain = 256;

    localparam real c_pi = 3.14159265358979323846;

    // Taylor series keeps elaboration free of math-library calls; 12 terms
    // are far below one LSB of error over [0, pi/2].
    function automatic int rom_entry(input int idx, input int addr_w, input int out_w);
        real x;
        real x2;
        real term;
        real s;
        int  full;
        x    = (c_pi / 2.0) * (real'(idx) + 0.5) / real'(1 << addr_w);
        x2   = x * x;
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x2 / (real'(2 * n) * real'(2 * n + 1));
            s    = s + term;
        end
        full = (1 << (out_w - 1)) - 1;
        return $rtoi(real'(full) * s + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : sine_quarter_rom
// Description : Quarter-wave sine magnitude table, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom
    import sine_dds_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default,
    parameter int OUT_W  = c_out_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [OUT_W-2:0]  o_mag
);

    logic [OUT_W-2:0] w_table [2**ADDR_W];

    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_entry
        localparam int c_val = rom_entry(gi, ADDR_W, OUT_W);
        assign w_table[gi] = (OUT_W-1)'(c_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mag <= '0;
        end else begin
            o_mag <= w_table[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sine_dds.sv
`default_nettype none
// ============================================================================
// Module      : sine_dds
// Description : Quarter-wave-table sine DDS, three-stage pipeline.
//               Optional SINE_DDS_AMP_EN adds an amplitude gain input.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_dds
    import sine_dds_pkg::*;
#(
    parameter int PHASE_W = c_phase_w_default,
    parameter int ADDR_W  = c_addr_w_default,
    parameter int OUT_W   = c_out_w_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_offset,
`ifdef SINE_DDS_AMP_EN
    input  logic [8:0]         amplitude,
`endif
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid
);

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] w_phase;
    logic [1:0]         w_quad;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [ADDR_W-1:0]  r_s1_addr;
    logic               r_s2_valid;
    logic               r_s2_sign;
    logic [OUT_W-2:0]   w_mag;
    logic [OUT_W-1:0]   w_signed;
    logic [OUT_W-1:0]   w_stage3;

    assign w_phase = r_acc + phase_offset;
    assign w_quad  = 2'(w_phase >> (PHASE_W - 2));
    assign w_idx   = ADDR_W'(w_phase >> (PHASE_W - 2 - ADDR_W));
    // Odd quadrants run the table backwards: 2^ADDR_W-1-idx is ~idx.
    assign w_addr  = ((w_quad == c_quad_q1) || (w_quad == c_quad_q3)) ? ~w_idx : w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
        end else begin
            if (clear) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= r_acc + freq_word;
            end
            r_s1_valid <= en;
            if (en) begin
                r_s1_addr <= w_addr;
                r_s1_sign <= w_quad[1];
            end
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
        end
    end

    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (r_s1_addr),
        .o_mag  (w_mag)
    );

    assign w_signed = r_s2_sign ? -{1'b0, w_mag} : {1'b0, w_mag};

`ifdef SINE_DDS_AMP_EN
    logic [8:0]           w_gain;
    logic signed [OUT_W+9:0] w_op_a;
    logic signed [OUT_W+9:0] w_op_b;
    logic signed [OUT_W+9:0] w_prod;

    assign w_gain   = (amplitude > 9'(c_unity_gain)) ? 9'(c_unity_gain) : amplitude;
    assign w_op_a   = {{10{w_signed[OUT_W-1]}}, w_signed};
    assign w_op_b   = {{(OUT_W+1){1'b0}}, w_gain};
    assign w_prod   = w_op_a * w_op_b;
    // Arithmetic shift floors toward negative infinity.
    assign w_stage3 = OUT_W'(w_prod >>> 8);
`else
    assign w_stage3 = w_signed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= r_s2_valid;
            if (r_s2_valid) begin
                sample_out <= w_stage3;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sine_dds.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_dds
// Description : Scoreboard bench for sine_dds with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_dds;

    typedef struct {
        int               due;
        logic             v;
        logic             chk;
        logic signed [8:0] val;
        int               tag;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic              clear;
    logic [23:0]       freq_word;
    logic [23:0]       phase_offset;
    logic [8:0]        amplitude;
    logic signed [8:0] sample_out;
    logic              sample_valid;

    int                ecnt;
    int                checks;
    int                errors;
    exp_t              sb[$];
    logic signed [8:0] hist [1024];

    sine_dds dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clear        (clear),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
`ifdef SINE_DDS_AMP_EN
        .amplitude    (amplitude),
`endif
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: pops the expectation due at this cycle and compares.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < ecnt) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL stale expectation due %0d at cycle %0d", e.due, ecnt);
        end
        if (sb.size() > 0 && sb[0].due == ecnt) begin
            e = sb.pop_front();
            checks++;
            if (sample_valid !== e.v) begin
                errors++;
                $display("FAIL valid cycle %0d: got %0b expected %0b", ecnt, sample_valid, e.v);
            end
            if (e.chk) begin
                checks++;
                if (sample_out !== e.val) begin
                    errors++;
                    $display("FAIL sample cycle %0d tag %0d: got %0d expected %0d",
                             ecnt, e.tag, sample_out, e.val);
                end
            end
            if (e.tag >= 0) hist[e.tag] = sample_out;
        end
    end

    task automatic drive(input logic e, input logic c, input logic [23:0] f,
                         input logic [23:0] o, input logic ck, input int val,
                         input int tag);
        exp_t x;
        en           = e;
        clear        = c;
        freq_word    = f;
        phase_offset = o;
        x.due = ecnt + 3;
        x.v   = e;
        x.chk = ck;
        x.val = 9'(val);
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 0, -1);
    endtask

    // Reset with en and clear also high: every in-flight sample is dropped.
    task automatic rst_pulse();
        exp_t x;
        while (sb.size() > 0 && sb[$].due >= ecnt + 1) void'(sb.pop_back());
        for (int i = 1; i <= 3; i++) begin
            x.due = ecnt + i;
            x.v   = 1'b0;
            x.chk = 1'b1;
            x.val = 9'sd0;
            x.tag = -1;
            sb.push_back(x);
        end
        rst   = 1'b1;
        en    = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        int ck;
        int val;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        en           = 1'b0;
        clear        = 1'b0;
        freq_word    = '0;
        phase_offset = '0;
        amplitude    = 9'd256;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset valid: got %0b expected 0", sample_valid);
        end
        checks++;
        if (sample_out !== 9'sd0) begin
            errors++;
            $display("FAIL reset sample: got %0d expected 0", sample_out);
        end
        rst = 1'b0;

        // Zero frequency, zero offset: smallest positive table entry.
        repeat (4) drive(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1, -1);

        // Offsets select quadrant peaks and zero-crossing neighbours.
        repeat (2) drive(1'b1, 1'b0, 24'h0, 24'h400000, 1'b1, 255, -1);
        drive(1'b1, 1'b0, 24'h0, 24'hC00000, 1'b1, -255, -1);
        drive(1'b1, 1'b0, 24'h0, 24'h800000, 1'b1, -1, -1);

        // en 1,0,1: output holds through the gap.
        drive(1'b1, 1'b0, 24'h0, 24'h400000, 1'b1, 255, -1);
        drive(1'b0, 1'b0, 24'h0, 24'h400000, 1'b1, 255, -1);
        drive(1'b1, 1'b0, 24'h0, 24'hC00000, 1'b1, -255, -1);

        // clear+en together at acc=0x123456: table entry 72 is 110.
        drive(1'b0, 1'b1, 24'h0, 24'h0, 1'b0, 0, -1);
        drive(1'b1, 1'b0, 24'h123456, 24'h0, 1'b1, 1, -1);
        drive(1'b1, 1'b1, 24'h123456, 24'h0, 1'b1, 110, -1);
        drive(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1, -1);

        // One full period: 0x004000 steps the table index by one per sample.
        drive(1'b0, 1'b1, 24'h0, 24'h0, 1'b0, 0, -1);
        for (int k = 0; k < 1024; k++) begin
            ck = 1;
            case (k)
                0:       val = 1;
                255:     val = 255;
                256:     val = 255;
                511:     val = 1;
                512:     val = -1;
                767:     val = -255;
                768:     val = -255;
                1023:    val = -1;
                default: begin ck = 0; val = 0; end
            endcase
            drive(1'b1, 1'b0, 24'h004000, 24'h0, ck[0], val, k);
        end
        // 1024 steps of 2^14 wrap the accumulator exactly back to zero.
        drive(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1, -1);

        // Reset mid-stream.
        repeat (2) drive(1'b1, 1'b0, 24'h0, 24'h400000, 1'b1, 255, -1);
        rst_pulse();
        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 0, -1);
        drive(1'b1, 1'b0, 24'h0, 24'h0, 1'b1, 1, -1);

`ifdef SINE_DDS_AMP_EN
        idle(3);
        amplitude = 9'd128;
        repeat (2) drive(1'b1, 1'b0, 24'h0, 24'h400000, 1'b1, 127, -1);
        drive(1'b1, 1'b0, 24'h0, 24'hC00000, 1'b1, -128, -1);
        idle(3);
        amplitude = 9'd300;
        drive(1'b1, 1'b0, 24'h0, 24'h400000, 1'b1, 255, -1);
        drive(1'b1, 1'b0, 24'h0, 24'hC00000, 1'b1, -255, -1);
        idle(3);
        amplitude = 9'd256;
`endif

        idle(3);
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        // Half-period antisymmetry over the captured period.
        for (int k = 0; k < 512; k += 37) begin
            checks++;
            if (hist[k] !== -hist[k+512]) begin
                errors++;
                $display("FAIL symmetry k=%0d: got %0d expected %0d", k, hist[k+512], -hist[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
